mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM stage of the 5-stage RISC-V pipeline, directly downstream of EX (alu/alucontrol).
- Takes the ALU result as the effective address, plus store data and load/store controls, and drives a single-outstanding data-memory request with wait states.
- Performs byte-lane steering and load sign/zero extension, then presents a registered result to WB.
- Back-pressures EX through a valid/ready handshake while a memory access is in flight.

Parameters:
- TIMEOUT_CYCLES, 16: dmem_ready wait limit; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX presents an instruction
- ex_ready  out  1  unit accepts the EX instruction this cycle
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_funct3  in  3  access size/sign (RV32I encoding)
- ex_alu_result  in  32  effective address, or result for non-memory ops
- ex_store_data  in  32  rs2 value for stores
- ex_rd  in  5  destination register
- ex_reg_write  in  1  instruction writes rd
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, [1:0] = 00
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-steered store data
- dmem_ready  in  1  request completes this cycle
- dmem_rdata  in  32  read word, valid when dmem_ready = 1
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_data  out  32  load data or passthrough ALU result
- wb_rd  out  5  destination register
- wb_reg_write  out  1  WB must write rd
- mem_err  out  1  one-cycle pulse with wb_valid on a faulting access

Behaviour:
- Clock/reset (already decided): one clock, clk; reset is synchronous and active-high, rst.
- Reset values: state IDLE; dmem_req, dmem_we, wb_valid, wb_reg_write, mem_err = 0; dmem_addr, dmem_be, dmem_wdata, wb_data, wb_rd = 0.
- FSM has two states, IDLE and WAIT. ex_ready = (state == IDLE), combinational.
- IDLE, ex_valid, non-memory op (read = write = 0):
  - Next edge: wb_valid = 1, wb_data = ex_alu_result, wb_rd and wb_reg_write passed through. Latency 1 cycle.
  - Throughput 1 instruction per cycle.
- IDLE, ex_valid, legal aligned memory op:
  - Latch address, controls, rd, funct3. Go to WAIT.
  - dmem_req = 1 from the next cycle.
- WAIT:
  - dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata are registered and held stable until the cycle dmem_ready = 1.
  - On that edge: go to IDLE and drop dmem_req.
  - Load: wb_valid = 1, wb_reg_write = latched reg_write, wb_data = formatted dmem_rdata.
  - Store: wb_valid = 1, wb_reg_write = 0.
  - Minimum memory-op latency, accept to wb_valid: 2 cycles, with dmem_ready in the first request cycle.
- dmem_ready while IDLE is ignored.
- Sizes and lanes, with a = addr[1:0]:
  - funct3 000 (byte): be = 0001<<a; wdata = {4{data[7:0]}}.
  - funct3 001 (half): be = 0011<<a; wdata = {2{data[15:0]}}.
  - funct3 010 (word): be = 1111; wdata = data.
  - Loads use the same be with we = 0.
- Load format: select the byte/half lane by a.
  - LB/LH (000/001): sign-extend.
  - LBU/LHU (100/101): zero-extend.
  - LW (010): full word.
- Faults (no bus request issued):
  - Half access with a[0] = 1, or word access with a != 00.
  - funct3 011/110/111, or store funct3 >= 011.
  - ex_mem_read and ex_mem_write both set.
  - Response on the next edge: wb_valid = 1, mem_err = 1, wb_reg_write = 0, wb_data = 0. State stays IDLE.
- Only one access is outstanding at a time. No new request is issued in the cycle dmem_ready is seen.
- rst asserted in WAIT: return to IDLE; dmem_req = 0 and wb_valid = 0 after the edge; the in-flight access is dropped with no WB pulse.
- ex_valid = 0: wb_valid = 0 next cycle; other wb_* outputs hold their last value.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle without dmem_ready.
  - When it reaches TIMEOUT_CYCLES, abort: dmem_req = 0, go to IDLE, and pulse wb_valid = 1, mem_err = 1, wb_reg_write = 0.
  - dmem_ready in the same cycle as the limit wins: normal completion.
- Not defined: no counter; WAIT persists until dmem_ready.

Test Plan:
- Reset, then non-memory stream: ex_alu_result = 0000000F and 00000005 on consecutive cycles, rd = 3 and 4, reg_write = 1 -> wb_valid on both following cycles, wb_data 0000000F then 00000005; ex_ready stays 1.
- SB: addr 00000102, data 000000AB, dmem_ready after 3 wait cycles -> dmem_addr 00000100, be 0100, wdata ABABABAB, req held 4 cycles; ex_ready = 0 throughout; wb_valid with wb_reg_write = 0.
- LB and LBU: addr 00000203, rdata 80FF1234 -> LB gives wb_data 00000080 sign-extended to FFFFFF80; LBU gives 00000080.
- LH at 00000006, rdata 8001AAAA -> be 1100, wb_data FFFF8001. LW at 00000002 -> no dmem_req, mem_err = 1, wb_reg_write = 0.
- rst asserted during WAIT of an LW -> dmem_req 0 next cycle, no wb_valid. Next LW at 00000010 with immediate ready -> wb_valid 2 cycles after accept.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, dmem_ready held 0 -> dmem_req drops after 4 WAIT cycles, mem_err pulse, ex_ready = 1 the following cycle.

Source files
------------

// File: rtl/mem_access_unit.sv
// RV32I MEM stage: single-outstanding data-memory access with lane steering and load formatting.
// Optional build macro MEM_TIMEOUT_EN adds a dmem_ready watchdog limited by TIMEOUT_CYCLES.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        mem_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0] state;

  logic [2:0] funct3_p1;
  logic [1:0] off_p1;
  logic [4:0] rd_p1;
  logic       reg_write_p1;
  logic       is_load_p1;

  logic [1:0] off_p0;
  logic       is_mem_p0;
  logic       fault_p0;
  logic       accept_mem_p0;
  logic       tmo_hit;

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] steer_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = rdata[{a, 3'b000} +: 8];
    h = rdata[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return 32'(b);
      3'b001:  return 32'(h);
      3'b100:  return {24'h000000, b};
      3'b101:  return {16'h0000, h};
      default: return rdata;
    endcase
  endfunction

  // Loads accept 000/001/010/100/101, stores only 000/001/010; halves and words must be aligned.
  function automatic logic access_fault(input logic rd_en, input logic wr_en,
                                        input logic [2:0] f3, input logic [1:0] a);
    if (rd_en && wr_en) return 1'b1;
    case (f3)
      3'b000:  return 1'b0;
      3'b001:  return a[0];
      3'b010:  return a != 2'b00;
      3'b100:  return wr_en;
      3'b101:  return wr_en || a[0];
      default: return 1'b1;
    endcase
  endfunction

  assign ex_ready = (state == ST_IDLE);

  always_comb begin
    off_p0        = ex_alu_result[1:0];
    is_mem_p0     = ex_mem_read || ex_mem_write;
    fault_p0      = access_fault(ex_mem_read, ex_mem_write, ex_funct3, off_p0);
    accept_mem_p0 = (state == ST_IDLE) && ex_valid && is_mem_p0 && !fault_p0;
  end

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (accept_mem_p0) begin
      tmo_cnt <= '0;
    end else if (state == ST_WAIT && !dmem_ready && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  // No watchdog: WAIT only ends on dmem_ready.
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  // ---- p0 -> p1: access context held while the request is outstanding
  always_ff @(posedge clk) begin
    if (accept_mem_p0) begin
      funct3_p1    <= ex_funct3;
      off_p1       <= off_p0;
      rd_p1        <= ex_rd;
      reg_write_p1 <= ex_reg_write;
      is_load_p1   <= ex_mem_read;
    end
  end

  // ---- p1 -> WB: bus control and retirement
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      mem_err      <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      mem_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ex_valid) begin
            if (!is_mem_p0) begin
              wb_valid     <= 1'b1;
              wb_data      <= ex_alu_result;
              wb_rd        <= ex_rd;
              wb_reg_write <= ex_reg_write;
            end else if (fault_p0) begin
              wb_valid     <= 1'b1;
              mem_err      <= 1'b1;
              wb_data      <= '0;
              wb_rd        <= ex_rd;
              wb_reg_write <= 1'b0;
            end else begin
              state      <= ST_WAIT;
              dmem_req   <= 1'b1;
              dmem_we    <= ex_mem_write;
              dmem_addr  <= {ex_alu_result[31:2], 2'b00};
              dmem_be    <= lane_be(ex_funct3, off_p0);
              dmem_wdata <= steer_wdata(ex_funct3, ex_store_data);
            end
          end
        end
        ST_WAIT: begin
          if (dmem_ready) begin
            state    <= ST_IDLE;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= rd_p1;
            if (is_load_p1) begin
              wb_reg_write <= reg_write_p1;
              wb_data      <= format_load(funct3_p1, off_p1, dmem_rdata);
            end else begin
              wb_reg_write <= 1'b0;
            end
          end else if (tmo_hit) begin
            state        <= ST_IDLE;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            wb_valid     <= 1'b1;
            mem_err      <= 1'b1;
            wb_rd        <= rd_p1;
            wb_reg_write <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table, hand sequences and randomized accesses vs. a model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        mem_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_valid      = 1'b0;
    ex_mem_read   = 1'b0;
    ex_mem_write  = 1'b0;
    ex_funct3     = 3'b000;
    ex_alu_result = '0;
    ex_store_data = '0;
    ex_rd         = '0;
    ex_reg_write  = 1'b0;
  endtask

  // Behavioural reference: size from funct3, lanes from byte offset, arithmetic sign extension.
  function automatic void model(input logic r, input logic w, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] sdata,
                                input logic [31:0] rdata, output logic fault,
                                output logic [31:0] waddr, output logic [3:0] be,
                                output logic [31:0] wdata, output logic [31:0] wb);
    int size;
    int a;
    longint v;
    a = int'(addr % 4);
    case (int'(f3) % 4)
      0: size = 1;
      1: size = 2;
      2: size = 4;
      default: size = 0;
    endcase
    fault = (r && w) || (size == 0) || (f3 >= 4 && (w || size == 4));
    if (!fault && (a % size) != 0) fault = 1'b1;
    waddr = addr - 32'(a);
    be = '0;
    wdata = sdata;
    wb = '0;
    if (!fault) begin
      be = 4'(((1 << size) - 1) << a);
      if (size == 1) wdata = 32'(sdata[7:0]) * 32'h01010101;
      else if (size == 2) wdata = 32'(sdata[15:0]) * 32'h00010001;
      v = (longint'(rdata) >> (8 * a)) & ((64'sd1 <<< (8 * size)) - 1);
      if (f3 < 4 && size < 4 && v >= (64'sd1 <<< (8 * size - 1))) v = v - (64'sd1 <<< (8 * size));
      wb = v[31:0];
    end
  endfunction

  task automatic do_mem(input string nm, input logic r, input logic w, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                        input int waits, input logic exp_fault, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_wb);
    logic [4:0] rdv;
    rdv = 5'($urandom);
    check({nm, " ex_ready before accept"}, 32'(ex_ready), 32'd1);
    ex_valid      = 1'b1;
    ex_mem_read   = r;
    ex_mem_write  = w;
    ex_funct3     = f3;
    ex_alu_result = addr;
    ex_store_data = sdata;
    ex_rd         = rdv;
    ex_reg_write  = r;
    step();
    idle_inputs();
    if (exp_fault) begin
      check({nm, " fault wb_valid"}, 32'(wb_valid), 32'd1);
      check({nm, " fault mem_err"}, 32'(mem_err), 32'd1);
      check({nm, " fault wb_reg_write"}, 32'(wb_reg_write), 32'd0);
      check({nm, " fault wb_data"}, wb_data, 32'd0);
      check({nm, " fault dmem_req"}, 32'(dmem_req), 32'd0);
      check({nm, " fault ex_ready"}, 32'(ex_ready), 32'd1);
    end else begin
      for (int k = 0; k <= waits; k++) begin
        check({nm, " dmem_req"}, 32'(dmem_req), 32'd1);
        check({nm, " dmem_we"}, 32'(dmem_we), 32'(w));
        check({nm, " dmem_addr"}, dmem_addr, exp_addr);
        check({nm, " dmem_be"}, 32'(dmem_be), 32'(exp_be));
        if (w) check({nm, " dmem_wdata"}, dmem_wdata, exp_wdata);
        check({nm, " ex_ready in wait"}, 32'(ex_ready), 32'd0);
        check({nm, " wb_valid in wait"}, 32'(wb_valid), 32'd0);
        dmem_ready = (k == waits);
        dmem_rdata = (k == waits) ? rdata : $urandom;
        step();
      end
      dmem_ready = 1'b0;
      check({nm, " wb_valid"}, 32'(wb_valid), 32'd1);
      check({nm, " mem_err"}, 32'(mem_err), 32'd0);
      check({nm, " dmem_req dropped"}, 32'(dmem_req), 32'd0);
      check({nm, " wb_reg_write"}, 32'(wb_reg_write), 32'(r));
      check({nm, " ex_ready after"}, 32'(ex_ready), 32'd1);
      if (r) begin
        check({nm, " wb_data"}, wb_data, exp_wb);
        check({nm, " wb_rd"}, 32'(wb_rd), 32'(rdv));
      end
    end
  endtask

  task automatic do_alu(input string nm, input logic [31:0] res, input logic [4:0] rd,
                        input logic rw, input logic last);
    ex_valid      = 1'b1;
    ex_mem_read   = 1'b0;
    ex_mem_write  = 1'b0;
    ex_alu_result = res;
    ex_rd         = rd;
    ex_reg_write  = rw;
    step();
    if (last) idle_inputs();
    check({nm, " wb_valid"}, 32'(wb_valid), 32'd1);
    check({nm, " wb_data"}, wb_data, res);
    check({nm, " wb_rd"}, 32'(wb_rd), 32'(rd));
    check({nm, " wb_reg_write"}, 32'(wb_reg_write), 32'(rw));
    check({nm, " mem_err"}, 32'(mem_err), 32'd0);
    check({nm, " ex_ready"}, 32'(ex_ready), 32'd1);
  endtask

  typedef struct {
    string       nm;
    logic        r;
    logic        w;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          waits;
    logic        fault;
    logic [31:0] waddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] wb;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{"SB 102",    0, 1, 3'b000, 32'h102, 32'h000000AB, 32'h0, 3, 0, 32'h100, 4'b0100, 32'hABABABAB, 32'h0};
    vecs[1]  = '{"LB 203",    1, 0, 3'b000, 32'h203, 32'h0, 32'h80FF1234, 1, 0, 32'h200, 4'b1000, 32'h0, 32'hFFFFFF80};
    vecs[2]  = '{"LBU 203",   1, 0, 3'b100, 32'h203, 32'h0, 32'h80FF1234, 2, 0, 32'h200, 4'b1000, 32'h0, 32'h00000080};
    vecs[3]  = '{"LH 006",    1, 0, 3'b001, 32'h006, 32'h0, 32'h8001AAAA, 0, 0, 32'h004, 4'b1100, 32'h0, 32'hFFFF8001};
    vecs[4]  = '{"LW 002",    1, 0, 3'b010, 32'h002, 32'h0, 32'h0, 0, 1, 32'h0, 4'b0000, 32'h0, 32'h0};
    vecs[5]  = '{"SH 00A",    0, 1, 3'b001, 32'h00A, 32'h1234BEEF, 32'h0, 2, 0, 32'h008, 4'b1100, 32'hBEEFBEEF, 32'h0};
    vecs[6]  = '{"SW 030",    0, 1, 3'b010, 32'h030, 32'hDEADBEEF, 32'h0, 0, 0, 32'h030, 4'b1111, 32'hDEADBEEF, 32'h0};
    vecs[7]  = '{"LHU 002",   1, 0, 3'b101, 32'h002, 32'h0, 32'h8001AAAA, 1, 0, 32'h000, 4'b1100, 32'h0, 32'h00008001};
    vecs[8]  = '{"LW 044",    1, 0, 3'b010, 32'h044, 32'h0, 32'hCAFEF00D, 3, 0, 32'h044, 4'b1111, 32'h0, 32'hCAFEF00D};
    vecs[9]  = '{"S f3=100",  0, 1, 3'b100, 32'h010, 32'h11, 32'h0, 0, 1, 32'h0, 4'b0000, 32'h0, 32'h0};
    vecs[10] = '{"RW both",   1, 1, 3'b010, 32'h010, 32'h11, 32'h0, 0, 1, 32'h0, 4'b0000, 32'h0, 32'h0};
    vecs[11] = '{"LH 005",    1, 0, 3'b001, 32'h005, 32'h0, 32'h0, 0, 1, 32'h0, 4'b0000, 32'h0, 32'h0};
    vecs[12] = '{"LB 001",    1, 0, 3'b000, 32'h001, 32'h0, 32'h80FF1234, 0, 0, 32'h000, 4'b0010, 32'h0, 32'h00000012};

    idle_inputs();
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    rst = 1'b1;
    repeat (3) step();
    check("reset ex_ready", 32'(ex_ready), 32'd1);
    check("reset dmem_req", 32'(dmem_req), 32'd0);
    check("reset dmem_we", 32'(dmem_we), 32'd0);
    check("reset dmem_addr", dmem_addr, 32'd0);
    check("reset dmem_be", 32'(dmem_be), 32'd0);
    check("reset dmem_wdata", dmem_wdata, 32'd0);
    check("reset wb_valid", 32'(wb_valid), 32'd0);
    check("reset wb_data", wb_data, 32'd0);
    check("reset wb_rd", 32'(wb_rd), 32'd0);
    check("reset wb_reg_write", 32'(wb_reg_write), 32'd0);
    check("reset mem_err", 32'(mem_err), 32'd0);
    rst = 1'b0;
    step();

    // Back-to-back non-memory ops, then a bubble
    do_alu("alu0", 32'h0000000F, 5'd3, 1'b1, 1'b0);
    do_alu("alu1", 32'h00000005, 5'd4, 1'b1, 1'b1);
    step();
    check("bubble wb_valid", 32'(wb_valid), 32'd0);
    check("bubble wb_data holds", wb_data, 32'h00000005);
    check("bubble wb_rd holds", 32'(wb_rd), 32'd4);

    // dmem_ready while idle must be ignored
    dmem_ready = 1'b1;
    dmem_rdata = 32'h12345678;
    step();
    dmem_ready = 1'b0;
    check("idle ready wb_valid", 32'(wb_valid), 32'd0);
    check("idle ready dmem_req", 32'(dmem_req), 32'd0);
    check("idle ready ex_ready", 32'(ex_ready), 32'd1);

    for (int i = 0; i < 13; i++) begin
      do_mem(vecs[i].nm, vecs[i].r, vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].sdata,
             vecs[i].rdata, vecs[i].waits, vecs[i].fault, vecs[i].waddr, vecs[i].be,
             vecs[i].wdata, vecs[i].wb);
    end

    // Reset during WAIT drops the access without a WB pulse
    ex_valid      = 1'b1;
    ex_mem_read   = 1'b1;
    ex_funct3     = 3'b010;
    ex_alu_result = 32'h20;
    ex_rd         = 5'd7;
    ex_reg_write  = 1'b1;
    step();
    idle_inputs();
    check("rstwait dmem_req before", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstwait dmem_req", 32'(dmem_req), 32'd0);
    check("rstwait wb_valid", 32'(wb_valid), 32'd0);
    check("rstwait ex_ready", 32'(ex_ready), 32'd1);
    step();
    check("rstwait no late wb", 32'(wb_valid), 32'd0);
    do_mem("LW 010 after rst", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h5A5A0F0F, 0,
           1'b0, 32'h10, 4'b1111, 32'h0, 32'h5A5A0F0F);

`ifdef MEM_TIMEOUT_EN
    ex_valid      = 1'b1;
    ex_mem_read   = 1'b1;
    ex_funct3     = 3'b010;
    ex_alu_result = 32'h40;
    ex_rd         = 5'd9;
    ex_reg_write  = 1'b1;
    step();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      check("tmo dmem_req held", 32'(dmem_req), 32'd1);
      check("tmo wb_valid quiet", 32'(wb_valid), 32'd0);
      step();
    end
    check("tmo dmem_req dropped", 32'(dmem_req), 32'd0);
    check("tmo wb_valid", 32'(wb_valid), 32'd1);
    check("tmo mem_err", 32'(mem_err), 32'd1);
    check("tmo wb_reg_write", 32'(wb_reg_write), 32'd0);
    check("tmo ex_ready", 32'(ex_ready), 32'd1);
    step();
    check("tmo pulse ends", 32'(mem_err), 32'd0);
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 80; i++) begin
      logic        r, w, fault;
      logic [2:0]  f3;
      logic [31:0] addr, sdata, rdata, waddr, wdata, wb;
      logic [3:0]  be;
      int          sel;
      if ($urandom_range(0, 9) < 2) begin
        do_alu("rnd alu", $urandom, 5'($urandom), 1'($urandom), 1'b1);
      end else begin
        sel = $urandom_range(0, 9);
        r = (sel <= 4) || (sel == 9);
        w = (sel >= 5);
        f3 = 3'($urandom_range(0, 7));
        addr = $urandom & 32'h000003FF;
        if ($urandom_range(0, 1) == 1) addr = addr & ~32'h3;
        sdata = $urandom;
        rdata = $urandom;
        model(r, w, f3, addr, sdata, rdata, fault, waddr, be, wdata, wb);
        do_mem("rnd mem", r, w, f3, addr, sdata, rdata, $urandom_range(0, 3),
               fault, waddr, be, wdata, wb);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
